// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling deserializer,
// and a valid/ready output register with frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int SYNC_STAGES = 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic [2:0]             idx_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             data_reg;
    logic                   valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    // Synchronizer flops reset to the idle (high) line level so release never fakes a start bit.
    assign sync_d = {sync_reg[SYNC_STAGES-2:0], rx_serial};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_d[gi];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            if (valid_reg && rx_ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg            <= '0;
                        shift_reg[idx_reg] <= rx_s;
                        if (idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            state_reg <= IDLE;
                            // A same-cycle transfer frees the register, so the new byte may load.
                            if (!valid_reg || rx_ready) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = frame_err_reg;
    assign rx_overrun   = overrun_reg;
    assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 16 clocks/bit, a second at 651 clocks/bit
// for the long-bit reset case. Expected values are hand-computed frame contents and timings.
module tb_uart_rx;

    localparam int CPB_A = 16;
    localparam int CPB_B = 651;
    localparam int LAT_A = 3 + CPB_A / 2 + 9 * CPB_A;
    localparam int LAT_B = 3 + CPB_B / 2 + 9 * CPB_B;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0;
    logic       rst_n_b = 1'b0;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic       rx_ready_a = 1'b1;
    logic       rx_ready_b = 1'b1;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       rx_frame_err_a, rx_frame_err_b;
    logic       rx_overrun_a, rx_overrun_b;
    logic       rx_busy_a, rx_busy_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .rx_serial(line_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_frame_err(rx_frame_err_a), .rx_overrun(rx_overrun_a), .rx_busy(rx_busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .rx_serial(line_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_frame_err(rx_frame_err_b), .rx_overrun(rx_overrun_b), .rx_busy(rx_busy_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors, sampled on the falling edge
    int         xfer_a = 0, vcyc_a = 0, ferr_a = 0, ovr_a = 0, vrise_a = 0;
    int         xfer_b = 0, ferr_b = 0, vrise_b = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    logic       prev_v_a = 1'b0, prev_v_b = 1'b0;

    always @(negedge clk) begin
        if (rx_valid_a && rx_ready_a) begin
            xfer_a <= xfer_a + 1;
            last_a <= rx_data_a;
        end
        if (rx_valid_a) vcyc_a <= vcyc_a + 1;
        if (rx_valid_a && !prev_v_a) vrise_a <= cyc;
        if (rx_frame_err_a) ferr_a <= ferr_a + 1;
        if (rx_overrun_a) ovr_a <= ovr_a + 1;
        prev_v_a <= rx_valid_a;

        if (rx_valid_b && rx_ready_b) begin
            xfer_b <= xfer_b + 1;
            last_b <= rx_data_b;
        end
        if (rx_valid_b && !prev_v_b) vrise_b <= cyc;
        if (rx_frame_err_b) ferr_b <= ferr_b + 1;
        prev_v_b <= rx_valid_b;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cyc = 0;
    int x0, v0, f0, o0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_zero(input bit sel, input string tag);
        if (sel)
            check(tag, {20'd0, rx_data_b, rx_valid_b, rx_frame_err_b, rx_overrun_b, rx_busy_b}, 32'd0);
        else
            check(tag, {20'd0, rx_data_a, rx_valid_a, rx_frame_err_a, rx_overrun_a, rx_busy_a}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame cycle by cycle; optionally pulses rx_ready (receiver A) or
    // asserts reset for 4 cycles at a given cycle offset from the start-bit edge.
    task automatic frame(input bit sel, input logic [7:0] b, input logic stop,
                         input logic idle_after, input int pulse_at, input int rst_at);
        int         cpb;
        logic [9:0] f;
        cpb = sel ? CPB_B : CPB_A;
        f = {stop, b, 1'b0};
        for (int c = 0; c < 10 * cpb; c++) begin
            if (sel) line_b = f[c / cpb];
            else     line_a = f[c / cpb];
            if (c == 0) start_cyc = cyc;
            if (pulse_at >= 0 && c == pulse_at)     rx_ready_a = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) rx_ready_a = 1'b0;
            if (rst_at >= 0 && c == rst_at) begin
                if (sel) rst_n_b = 1'b0;
                else     rst_n_a = 1'b0;
                #1;
                check_zero(sel, "reset_mid_frame");
            end
            if (rst_at >= 0 && c == rst_at + 4) begin
                if (sel) rst_n_b = 1'b1;
                else     rst_n_a = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (sel) line_b = idle_after;
        else     line_a = idle_after;
    endtask

    initial begin
        idle(3);
        check_zero(1'b0, "reset_a");
        check_zero(1'b1, "reset_b");
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        idle(5);

        // Clean frame, consumer always ready
        x0 = xfer_a; v0 = vcyc_a; f0 = ferr_a; o0 = ovr_a;
        frame(1'b0, 8'hA5, 1'b1, 1'b1, -1, -1);
        check("a5_xfer_count", xfer_a - x0, 1);
        check("a5_data", last_a, 8'hA5);
        check("a5_valid_cycles", vcyc_a - v0, 1);
        check("a5_latency", vrise_a - start_cyc, LAT_A);
        check("a5_flags", (ferr_a - f0) + (ovr_a - o0), 0);
        check("a5_busy_after", rx_busy_a, 1'b0);
        idle(10);

        // Short glitch on an idle line
        x0 = xfer_a; v0 = vcyc_a; f0 = ferr_a;
        line_a = 1'b0;
        idle(5);
        check("glitch_busy_during", rx_busy_a, 1'b1);
        line_a = 1'b1;
        idle(20);
        check("glitch_busy_after", rx_busy_a, 1'b0);
        check("glitch_no_valid", vcyc_a - v0, 0);
        check("glitch_no_ferr", ferr_a - f0, 0);

        // Bad stop bit, then break, then a good frame
        v0 = vcyc_a; f0 = ferr_a;
        frame(1'b0, 8'h3C, 1'b0, 1'b1, -1, -1);
        idle(10);
        check("3c_ferr_count", ferr_a - f0, 1);
        check("3c_no_valid", vcyc_a - v0, 0);
        f0 = ferr_a;
        frame(1'b0, 8'h00, 1'b0, 1'b0, -1, -1);
        idle(100);
        check("break_busy_low_line", rx_busy_a, 1'b1);
        line_a = 1'b1;
        idle(10);
        check("break_single_ferr", ferr_a - f0, 1);
        check("break_busy_after", rx_busy_a, 1'b0);
        x0 = xfer_a; f0 = ferr_a;
        frame(1'b0, 8'h81, 1'b1, 1'b1, -1, -1);
        idle(5);
        check("81_xfer_count", xfer_a - x0, 1);
        check("81_data", last_a, 8'h81);
        check("81_no_ferr", ferr_a - f0, 0);

        // Overrun: consumer stalled across two frames
        rx_ready_a = 1'b0;
        x0 = xfer_a; o0 = ovr_a;
        frame(1'b0, 8'h11, 1'b1, 1'b1, -1, -1);
        frame(1'b0, 8'h22, 1'b1, 1'b1, -1, -1);
        idle(5);
        check("ovr_valid_held", rx_valid_a, 1'b1);
        check("ovr_data_held", rx_data_a, 8'h11);
        check("ovr_pulse_count", ovr_a - o0, 1);
        check("ovr_no_xfer", xfer_a - x0, 0);
        rx_ready_a = 1'b1;
        idle(1);
        rx_ready_a = 1'b0;
        idle(2);
        check("ovr_drain_count", xfer_a - x0, 1);
        check("ovr_drain_data", last_a, 8'h11);
        check("ovr_valid_cleared", rx_valid_a, 1'b0);

        // Transfer in the same cycle the next good frame completes
        frame(1'b0, 8'h11, 1'b1, 1'b1, -1, -1);
        idle(5);
        x0 = xfer_a; o0 = ovr_a;
        frame(1'b0, 8'h22, 1'b1, 1'b1, LAT_A - 1, -1);
        idle(5);
        check("same_cycle_xfer_count", xfer_a - x0, 1);
        check("same_cycle_xfer_data", last_a, 8'h11);
        check("same_cycle_new_data", rx_data_a, 8'h22);
        check("same_cycle_valid", rx_valid_a, 1'b1);
        check("same_cycle_no_ovr", ovr_a - o0, 0);

        // Reset during data bit 4 (output register still holding 0x22), then 0x5A
        x0 = xfer_a; o0 = ovr_a; f0 = ferr_a;
        frame(1'b0, 8'hF0, 1'b1, 1'b1, -1, 5 * CPB_A + 2);
        idle(20);
        check("rst_a_no_valid", rx_valid_a, 1'b0);
        check("rst_a_busy", rx_busy_a, 1'b0);
        frame(1'b0, 8'h5A, 1'b1, 1'b1, -1, -1);
        idle(5);
        check("rst_a_5a_valid", rx_valid_a, 1'b1);
        check("rst_a_5a_data", rx_data_a, 8'h5A);
        rx_ready_a = 1'b1;
        idle(1);
        rx_ready_a = 1'b0;
        idle(2);
        check("rst_a_xfer_count", xfer_a - x0, 1);
        check("rst_a_xfer_data", last_a, 8'h5A);
        check("rst_a_flags", (ferr_a - f0) + (ovr_a - o0), 0);

        // Long-bit receiver: 0xFF aborted by reset, then 0x00
        x0 = xfer_b; f0 = ferr_b;
        frame(1'b1, 8'hFF, 1'b1, 1'b1, -1, 5 * CPB_B + 2);
        idle(20);
        check("rst_b_no_xfer", xfer_b - x0, 0);
        check("rst_b_busy", rx_busy_b, 1'b0);
        frame(1'b1, 8'h00, 1'b1, 1'b1, -1, -1);
        idle(5);
        check("rst_b_xfer_count", xfer_b - x0, 1);
        check("rst_b_xfer_data", last_b, 8'h00);
        check("rst_b_latency", vrise_b - start_cyc, LAT_B);
        check("rst_b_no_ferr", ferr_b - f0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 651, meaning clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all flops on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_serial  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte; valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  byte available for the consumer.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts; transfer occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-008 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port rx_overrun  output  1  one-cycle pulse: good byte dropped because the output register was occupied.
REQ-010 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx_serial through a 2-flop synchronizer (both flops reset to 1); all logic below uses the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with one bit-timing counter (width ceil(log2(CLKS_PER_BIT))) and a 3-bit bit index.
REQ-013 IDLE: on rx_s=0 SHALL enter START with the counter cleared.
REQ-014 START: SHALL sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (integer division); sample 1 -> IDLE (glitch rejected, no flag); sample 0 -> DATA with the counter and bit index cleared.
REQ-015 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (counter reaches CLKS_PER_BIT-1, then wraps to 0) into shift-register bit [index], LSB first; after the sample at index 7 it SHALL enter STOP.
REQ-016 STOP: SHALL sample rx_s after CLKS_PER_BIT cycles; sample 1 -> good frame, go to IDLE; sample 0 -> pulse rx_frame_err, discard the byte, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL remain until rx_s=1, then enter IDLE; a held-low line (break) SHALL produce exactly one rx_frame_err.
REQ-018 On a good frame with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle, SHALL load rx_data and hold rx_valid=1 from the next cycle.
REQ-019 On a good frame with rx_valid=1 and rx_ready=0, SHALL keep the old rx_data, keep rx_valid=1, and pulse rx_overrun in the next cycle.
REQ-020 SHALL clear rx_valid on the cycle after a transfer unless REQ-018 reloads it; rx_data SHALL not change while rx_valid=1 except through REQ-018.
REQ-021 Latency: a rx_serial falling edge SHALL reach rx_s 2 cycles later; rx_valid SHALL rise 1 cycle after the stop sample, which occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the line edge (±1 for synchronizer sampling).
REQ-022 The receiver SHALL accept a new start bit in IDLE regardless of the rx_valid state (the output register is independent of the deserializer).

Reset
REQ-023 With rst_n=0 SHALL immediately force: state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no flag; after release, reception SHALL restart only on a new falling edge of rx_s.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-025 Send 0xA5 with proper 8N1 timing, rx_ready=1 -> rx_valid high for exactly 1 cycle with rx_data=0xA5, no flags, rx_busy low again before the next start bit.
REQ-026 Low pulse of 5 clk on idle line -> no rx_valid, no rx_frame_err, state back in IDLE after the half-bit sample.
REQ-027 Send 0x3C with stop bit low, then line high -> single rx_frame_err pulse, rx_valid stays 0; a following 0x81 frame is received correctly.
REQ-028 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, one rx_overrun pulse after the second stop bit; raise rx_ready -> single transfer of 0x11.
REQ-029 rx_ready pulsed high in the cycle the second good frame completes -> 0x11 transferred, rx_data=0x22 next cycle with rx_valid=1, no rx_overrun.
REQ-030 Assert rst_n=0 during data bit 4 of a frame, release, send 0x5A -> all outputs 0 during reset; only 0x5A delivered afterwards; repeat with CLKS_PER_BIT=651 for a 0xFF/0x00 pair.
